// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbiter for the shared memory port: fetch, data and debug requesters
// Debug always wins; fetch and data alternate on ties; one transaction is in flight at a time.
module mem_port_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk_i_w,
  input  logic          rst_i_w,
  input  logic          if_req_i_w,
  input  logic [AW-1:0] if_addr_i_w,
  output logic          if_gnt_o_r,
  output logic          if_vld_o_r,
  output logic [DW-1:0] if_rdat_o_r,
  input  logic          ds_req_i_w,
  input  logic          ds_wr_i_w,
  input  logic [AW-1:0] ds_addr_i_w,
  input  logic [DW-1:0] ds_wdat_i_w,
  output logic          ds_gnt_o_r,
  output logic          ds_vld_o_r,
  output logic [DW-1:0] ds_rdat_o_r,
  input  logic          dbg_req_i_w,
  input  logic          dbg_wr_i_w,
  input  logic [AW-1:0] dbg_addr_i_w,
  input  logic [DW-1:0] dbg_wdat_i_w,
  output logic          dbg_gnt_o_r,
  output logic          dbg_vld_o_r,
  output logic [DW-1:0] dbg_rdat_o_r,
  output logic          mem_en_o_r,
  output logic          mem_wr_o_r,
  output logic [AW-1:0] mem_addr_o_r,
  output logic [DW-1:0] mem_wdat_o_r,
  input  logic [DW-1:0] mem_rdat_i_w,
  output logic          busy_o_r
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_DS, OWN_DBG} owner_t;

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  state_t     r_state;
  owner_t     r_owner;
  logic [2:0] r_lat_cnt;
  logic       r_last_ds;

  logic w_pick_dbg;
  logic w_pick_ds;
  logic w_pick_if;
  logic w_pick_any;

  // r_last_ds=1 means data was served last, so fetch takes the next tie.
  assign w_pick_dbg = dbg_req_i_w;
  assign w_pick_ds  = !dbg_req_i_w && ds_req_i_w && (!if_req_i_w || !r_last_ds);
  assign w_pick_if  = !dbg_req_i_w && if_req_i_w && !w_pick_ds;
  assign w_pick_any = w_pick_dbg || w_pick_ds || w_pick_if;

  always_ff @(posedge clk_i_w or negedge rst_i_w) begin
    if (!rst_i_w) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_IF;
      r_lat_cnt    <= 3'd0;
      r_last_ds    <= 1'b1;
      if_gnt_o_r   <= 1'b0;
      if_vld_o_r   <= 1'b0;
      if_rdat_o_r  <= '0;
      ds_gnt_o_r   <= 1'b0;
      ds_vld_o_r   <= 1'b0;
      ds_rdat_o_r  <= '0;
      dbg_gnt_o_r  <= 1'b0;
      dbg_vld_o_r  <= 1'b0;
      dbg_rdat_o_r <= '0;
      mem_en_o_r   <= 1'b0;
      mem_wr_o_r   <= 1'b0;
      mem_addr_o_r <= '0;
      mem_wdat_o_r <= '0;
      busy_o_r     <= 1'b0;
    end else begin
      if_gnt_o_r  <= 1'b0;
      ds_gnt_o_r  <= 1'b0;
      dbg_gnt_o_r <= 1'b0;
      if_vld_o_r  <= 1'b0;
      ds_vld_o_r  <= 1'b0;
      dbg_vld_o_r <= 1'b0;
      mem_en_o_r  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_pick_dbg) begin
            r_owner      <= OWN_DBG;
            dbg_gnt_o_r  <= 1'b1;
            mem_wr_o_r   <= dbg_wr_i_w;
            mem_addr_o_r <= dbg_addr_i_w;
            mem_wdat_o_r <= dbg_wdat_i_w;
          end else if (w_pick_ds) begin
            r_owner      <= OWN_DS;
            r_last_ds    <= 1'b1;
            ds_gnt_o_r   <= 1'b1;
            mem_wr_o_r   <= ds_wr_i_w;
            mem_addr_o_r <= ds_addr_i_w;
            mem_wdat_o_r <= ds_wdat_i_w;
          end else if (w_pick_if) begin
            r_owner      <= OWN_IF;
            r_last_ds    <= 1'b0;
            if_gnt_o_r   <= 1'b1;
            mem_wr_o_r   <= 1'b0;
            mem_addr_o_r <= if_addr_i_w;
          end
          if (w_pick_any) begin
            r_state    <= S_ISSUE;
            mem_en_o_r <= 1'b1;
            busy_o_r   <= 1'b1;
          end
        end

        S_ISSUE: begin
          r_state   <= S_WAIT;
          r_lat_cnt <= LAT_LOAD;
        end

        S_WAIT: begin
          if (r_lat_cnt == 3'd0) begin
            r_state <= S_RESP;
            // Writes still pulse vld, but leave the owner's read data untouched.
            case (r_owner)
              OWN_DBG: begin
                dbg_vld_o_r <= 1'b1;
                if (!mem_wr_o_r) dbg_rdat_o_r <= mem_rdat_i_w;
              end
              OWN_DS: begin
                ds_vld_o_r <= 1'b1;
                if (!mem_wr_o_r) ds_rdat_o_r <= mem_rdat_i_w;
              end
              default: begin
                if_vld_o_r <= 1'b1;
                if (!mem_wr_o_r) if_rdat_o_r <= mem_rdat_i_w;
              end
            endcase
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          busy_o_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
